// File: rtl/param_deserializer_arb_pkg.sv
// Shared definitions for the Nibbler deserialized word register:
// subword geometry, index width and the sequencer state encoding.
package param_DeserializerPkg;

  localparam int NIBBLE_W    = 4;
  localparam int NUM_NIBBLES = 8;
  localparam int WORD_W      = NIBBLE_W * NUM_NIBBLES;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

endpackage

// File: rtl/param_deserializer_arb_nibble_word_reg.sv
// Eight-entry nibble storage for the deserialized word.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high clear of all subwords
//   i_we     write enable for subword i_idx
//   i_idx    subword index 0..7
//   i_wdata  nibble to write
//   o_word   all subwords concatenated, subword k at bits [4k+3:4k]
module param_NibbleWordReg
  import param_DeserializerPkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_idx,
  input  logic [NIBBLE_W-1:0] i_wdata,
  output logic [WORD_W-1:0]   o_word
);

  logic [NIBBLE_W-1:0] r_mem [NUM_NIBBLES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_NIBBLES; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  for (genvar g = 0; g < NUM_NIBBLES; g++) begin : g_cat
    assign o_word[g*NIBBLE_W +: NIBBLE_W] = r_mem[g];
  end

endmodule

// File: rtl/param_deserializer_arb.sv
// Two-requester round-robin arbiter and sequencer that assembles eight
// nibbles (LS nibble first) from one granted producer into a 32-bit word
// and offers it on a valid/ready output port.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   r0_val/r0_rdy/r0_data   requester 0 (ALU writeback) nibble stream
//   r1_val/r1_rdy/r1_data   requester 1 (load data) nibble stream
//   out_val/out_rdy         assembled word handshake
//   out_data                assembled word (storage contents in every state)
//   out_src                 requester that produced out_data
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no rdy; arbitrate on any val, latch winner into grant
// FILL    | rdy to grant only; accept nibbles into subword[index] 0..7
// FULL    | out_val high until out_rdy; then prio flips to the loser
module param_deserializer_arb
  import param_DeserializerPkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_val,
  output logic                r0_rdy,
  input  logic [NIBBLE_W-1:0] r0_data,
  input  logic                r1_val,
  output logic                r1_rdy,
  input  logic [NIBBLE_W-1:0] r1_data,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_src
);

  state_t              r_state, w_state_nxt;
  logic                r_grant, w_grant_nxt;
  logic                r_prio,  w_prio_nxt;
  logic [IDX_W-1:0]    r_idx,   w_idx_nxt;
  logic                w_we;
  logic                w_gnt_val;
  logic [NIBBLE_W-1:0] w_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_prio  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_prio  <= w_prio_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_prio_nxt  = r_prio;
    w_idx_nxt   = r_idx;
    w_we        = 1'b0;
    w_gnt_val   = r_grant ? r1_val  : r0_val;
    w_wdata     = r_grant ? r1_data : r0_data;
    case (r_state)
      ST_IDLE: begin
        if (r0_val || r1_val) begin
          w_state_nxt = ST_FILL;
          w_idx_nxt   = '0;
          // Contention goes to prio; otherwise the lone requester wins.
          w_grant_nxt = (r0_val && r1_val) ? r_prio : r1_val;
        end
      end
      ST_FILL: begin
        // rdy is high for the granted requester throughout FILL, so a
        // granted val is a handshake.
        if (w_gnt_val) begin
          w_we      = 1'b1;
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == IDX_W'(NUM_NIBBLES - 1)) w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (out_rdy) begin
          w_state_nxt = ST_IDLE;
          w_prio_nxt  = ~r_grant;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  param_NibbleWordReg u_word (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_idx   (r_idx),
    .i_wdata (w_wdata),
    .o_word  (out_data)
  );

  assign r0_rdy  = (r_state == ST_FILL) && !r_grant;
  assign r1_rdy  = (r_state == ST_FILL) &&  r_grant;
  assign out_val = (r_state == ST_FULL);
  assign out_src = r_grant;

endmodule

// File: tb/tb_param_deserializer_arb.sv
module tb_param_deserializer_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_val = 1'b0, r1_val = 1'b0;
  logic [3:0]  r0_data = '0, r1_data = '0;
  logic        r0_rdy, r1_rdy;
  logic        out_val, out_src;
  logic        out_rdy = 1'b1;
  logic [31:0] out_data;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;

  typedef struct {
    bit          src;
    logic [31:0] word;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          src;
    logic [31:0] word;
    int          stall;
  } vec_t;
  vec_t vecs[4];

  param_deserializer_arb dut (
    .clk(clk), .reset(reset),
    .r0_val(r0_val), .r0_rdy(r0_rdy), .r0_data(r0_data),
    .r1_val(r1_val), .r1_rdy(r1_rdy), .r1_data(r1_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .out_src(out_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Word handshake scoreboard: out_val & out_rdy seen between edges means
  // the word is taken at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_val && out_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", out_data, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", out_data, e.word);
        chk("sb_src", {31'd0, out_src}, {31'd0, e.src});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r0_val = 1'b0; r1_val = 1'b0; out_rdy = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_sb_empty(string name, int limit);
    int b;
    b = 0;
    while (sb.size() != 0 && b < limit) begin step(); b++; end
    chk(name, sb.size(), 0);
  endtask

  // Stream one word from requester src, optionally stalling 'stall' cycles
  // after four nibbles, optionally toggling the other requester with 4'hF.
  task automatic send_word(input bit src, input logic [31:0] word,
                           input int stall, input bit toggle_other);
    int  k, stall_cnt, t0, b;
    bit  v, rdy_now, oth_rdy;
    exp_t e;
    k = 0; stall_cnt = 0; b = 0; t0 = cyc;
    e.src = src; e.word = word;
    sb.push_back(e);
    while (k < 8 && b < 200) begin
      v = !(k == 4 && stall_cnt < stall);
      if (src) begin
        r1_val = v; r1_data = word[4*k +: 4];
        r0_val = toggle_other & b[0]; r0_data = 4'hF;
      end else begin
        r0_val = v; r0_data = word[4*k +: 4];
        r1_val = toggle_other & b[0]; r1_data = 4'hF;
      end
      rdy_now = src ? r1_rdy : r0_rdy;
      oth_rdy = src ? r0_rdy : r1_rdy;
      if (toggle_other) chk("other_rdy_low", {31'd0, oth_rdy}, 32'd0);
      if (!v) chk("stall_rdy_held", {31'd0, rdy_now}, 32'd1);
      step();
      if (v && rdy_now) k++;
      else if (!v) stall_cnt++;
      b++;
    end
    chk("word_budget", {31'd0, (k == 8)}, 32'd1);
    r0_val = 1'b0; r1_val = 1'b0;
    chk("out_val_full", {31'd0, out_val}, 32'd1);
    chk("latency", cyc - t0, 9 + stall);
    step();
    chk("back_to_idle", {31'd0, out_val}, 32'd0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int   b;
    int   n;
    exp_t e;

    vecs[0] = '{src: 1'b0, word: 32'h8765_4321, stall: 0};
    vecs[1] = '{src: 1'b1, word: 32'hDEAD_BEEF, stall: 5};
    vecs[2] = '{src: 1'b0, word: 32'h0F1E_2D3C, stall: 0};
    vecs[3] = '{src: 1'b1, word: 32'hA5C3_961E, stall: 0};

    do_reset();
    chk("rst_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_r0_rdy",  {31'd0, r0_rdy},  32'd0);
    chk("rst_r1_rdy",  {31'd0, r1_rdy},  32'd0);
    chk("rst_out_src", {31'd0, out_src}, 32'd0);
    chk("rst_out_data", out_data, 32'h0);

    for (int i = 0; i < 4; i++)
      send_word(vecs[i].src, vecs[i].word, vecs[i].stall, 1'b0);

    // Last word came from r1, so prio is 0; storage holds a nonzero word.
    send_word(1'b0, 32'h0000_0000, 0, 1'b1);

    // Contention from reset: alternation A/0, 5/1, A/0.
    do_reset();
    r0_val = 1'b1; r0_data = 4'hA;
    r1_val = 1'b1; r1_data = 4'h5;
    e.src = 1'b0; e.word = 32'hAAAA_AAAA; sb.push_back(e);
    e.src = 1'b1; e.word = 32'h5555_5555; sb.push_back(e);
    e.src = 1'b0; e.word = 32'hAAAA_AAAA; sb.push_back(e);
    wait_sb_empty("contention_done", 60);
    r0_val = 1'b0; r1_val = 1'b0;

    // Backpressure: out_rdy low 20 cycles in FULL while r0 keeps val.
    do_reset();
    out_rdy = 1'b0;
    r0_val = 1'b1; r0_data = 4'h3;
    b = 0;
    while (!out_val && b < 30) begin step(); b++; end
    chk("bp_reach_full", {31'd0, out_val}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_out_val", {31'd0, out_val}, 32'd1);
      chk("bp_out_data", out_data, 32'h3333_3333);
      chk("bp_r0_rdy", {31'd0, r0_rdy}, 32'd0);
      step();
    end
    e.src = 1'b0; e.word = 32'h3333_3333; sb.push_back(e);
    out_rdy = 1'b1;
    step();
    chk("bp_idle_out_val", {31'd0, out_val}, 32'd0);
    chk("bp_idle_r0_rdy", {31'd0, r0_rdy}, 32'd0);
    step();
    chk("bp_regrant_r0", {31'd0, r0_rdy}, 32'd1);
    e.src = 1'b0; e.word = 32'h3333_3333; sb.push_back(e);
    wait_sb_empty("bp_second_word", 20);
    r0_val = 1'b0;
    step();

    // Reset mid-FILL after 4 nibbles from r1.
    do_reset();
    r1_val = 1'b1; r1_data = 4'h9;
    n = 0; b = 0;
    while (n < 4 && b < 20) begin
      bit rd;
      rd = r1_rdy;
      step();
      if (rd) n++;
      b++;
    end
    chk("midfill_progress", n, 4);
    reset = 1'b1; r1_val = 1'b0;
    step();
    reset = 1'b0;
    chk("midrst_out_val", {31'd0, out_val}, 32'd0);
    chk("midrst_r0_rdy",  {31'd0, r0_rdy},  32'd0);
    chk("midrst_r1_rdy",  {31'd0, r1_rdy},  32'd0);
    chk("midrst_out_src", {31'd0, out_src}, 32'd0);
    chk("midrst_out_data", out_data, 32'h0);
    send_word(1'b1, 32'h1357_9BDF, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
